seven_segment_scan_controller: RTL

- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Latches a packed nibble word plus per-digit decimal-point and blank masks.
- Scans one digit per refresh slot, driving active-low anode enables and the shared 8-bit segment bus. Segments a..g are on led[7:1] and dp is on led[0].
- Sits between the numeric-result/debug logic and the board display pins. It generalises single-digit decoding to N digits, optional hex glyphs, and leading-zero suppression.

---
 rtl/seven_segment_scan_controller_pkg.sv | 57 +++++
 rtl/seven_segment_scan_controller_glyph_decoder.sv | 22 ++
 rtl/seven_segment_scan_controller.sv | 117 +++++++++++
 3 files changed

// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared constants for the seven-segment scan controller: segment glyphs
// (a..g, active-low), the drive polarity and the ghost-blank dead time.
// Ghost blanking is enabled by defining SEVEN_SEGMENT_GHOST_BLANK_EN.
package seven_segment_scan_controller_pkg;

  // Segments and anodes are both driven low to light.
  localparam logic SEG_ON = 1'b0;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Whole segment bus dark, dp included.
  localparam logic [7:0] LED_OFF = {SEG_BLANK, ~SEG_ON};

  // Cycles at the start of each slot with all digits off (ghost-blank build).
  localparam int DEAD_CYCLES = 2;

  // Glyph for a nibble; hex letters are always returned, gating is the caller's job.
  function automatic logic [6:0] seg_lookup(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_scan_controller_glyph_decoder.sv
// Combinational glyph decoder: one nibble plus dp/blank/hex_mode to the
// active-low {a,b,c,d,e,f,g,dp} bus.
module seven_segment_glyph_decoder
  import seven_segment_scan_controller_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] led
);

  // Dark when blanked or when a hex value arrives outside hex mode.
  always_comb begin
    // NOTE: default assigned first so every path drives led and no latch is inferred.
    led = LED_OFF;
    if (!blank && (hex_mode || nibble < 4'd10)) begin
      led = {seg_lookup(nibble), dp ? SEG_ON : ~SEG_ON};
    end
  end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// N-digit time-multiplexed seven-segment driver (common anode, active-low).
// Shadow registers take load; each slot's pattern is fixed at the slot start.
// Optional: SEVEN_SEGMENT_GHOST_BLANK_EN adds DEAD_CYCLES of all-off per slot.
module seven_segment_scan_controller
  import seven_segment_scan_controller_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_PERIOD = 50000,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic [N_DIGITS-1:0]   blank_in,
  input  logic                  hex_mode,
  input  logic                  lz_suppress,
  output logic [N_DIGITS-1:0]   anode,
  output logic [7:0]            led,
  output logic                  slot_tick
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] shadow_digits;
  logic [N_DIGITS-1:0]   shadow_dp;
  logic [N_DIGITS-1:0]   shadow_blank;
  logic                  armed;
  logic [N_DIGITS-1:0]   lead_zero;
  logic [3:0]            cur_nibble;
  logic [7:0]            glyph_led;
  logic [N_DIGITS-1:0]   disp_anode;
  logic [7:0]            disp_led;

  // Refresh counter and scan index; slot_tick marks the cycle the index moved.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      cnt       <= '0;
      idx       <= '0;
      slot_tick <= 1'b0;
    end else if (cnt == CNT_W'(DIGIT_PERIOD - 1)) begin
      cnt       <= '0;
      idx       <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      slot_tick <= 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
      slot_tick <= 1'b0;
    end
  end

  // Shadow capture; armed keeps all anodes off until the first load.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '1;
      armed         <= 1'b0;
    end else if (load) begin
      shadow_digits <= digits_in;
      shadow_dp     <= dp_in;
      shadow_blank  <= blank_in;
      armed         <= 1'b1;
    end
  end

  // Leading zeros: a digit and everything above it are zero with no dp lit; digit 0 always shows.
  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run          = run & (shadow_digits[4*i +: 4] == 4'h0) & ~shadow_dp[i];
      lead_zero[i] = run & lz_suppress & (i != 0);
    end
  end

  assign cur_nibble = shadow_digits[4*int'(idx) +: 4];

  seven_segment_glyph_decoder u_decoder (
    .nibble   (cur_nibble),
    .hex_mode (hex_mode),
    .blank    (shadow_blank[idx] | lead_zero[idx]),
    .dp       (shadow_dp[idx]),
    .led      (glyph_led)
  );

  // Slot pattern is taken once, the cycle after the index advances, so loads never tear a slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_anode <= '1;
      disp_led   <= LED_OFF;
    end else if (slot_tick && armed) begin
      disp_anode <= ~(N_DIGITS'(1) << idx);
      disp_led   <= glyph_led;
    end
  end

`ifdef SEVEN_SEGMENT_GHOST_BLANK_EN
  // Dead time at the start of each slot hides the previous digit's charge.
  always_comb begin
    anode = disp_anode;
    led   = disp_led;
    if (cnt < CNT_W'(DEAD_CYCLES)) begin
      anode = '1;
      led   = LED_OFF;
    end
  end
`else
  assign anode = disp_anode;
  assign led   = disp_led;
`endif

endmodule
